// File: rtl/depp_pkg.sv
// Shared constants for the DEPP slave controller: bus width, parameter defaults, FSM encoding.
// The optional address auto-increment is enabled with the DEPP_AUTOINC_EN macro in depp_reg_ctrl.
package depp_pkg;
  localparam int DEPP_DW = 8;

  localparam int                 SYNC_STAGES_DEF   = 2;
  localparam int                 ACK_TIMEOUT_DEF   = 255;
  localparam logic [DEPP_DW-1:0] TIMEOUT_RDATA_DEF = 8'hFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DREQ  = 3'd2;
  localparam logic [2:0] ST_DWAIT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
endpackage

// File: rtl/depp_sync.sv
// Multi-stage flip-flop synchronizer with a selectable reset level.
module depp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{i_rst_val}};
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/depp_reg_ctrl.sv
// DEPP slave: synchronizes host strobes and maps each data cycle to one access on an 8-bit register bus.
// Define DEPP_AUTOINC_EN to advance reg_addr after every data cycle.
module depp_reg_ctrl
  import depp_pkg::*;
#(
  parameter int                 SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int                 ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
  parameter logic [DEPP_DW-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_astb,
  input  logic               a_dstb,
  input  logic               a_write,
  inout  wire  [DEPP_DW-1:0] a_db,
  output logic               a_wait,
  output logic [DEPP_DW-1:0] reg_addr,
  output logic [DEPP_DW-1:0] reg_wdata,
  output logic               reg_we,
  output logic               reg_re,
  input  logic [DEPP_DW-1:0] reg_rdata,
  input  logic               reg_ack,
  output logic               timeout,
  output logic               proto_err
);
  // Last count value before the cycle is forced complete; the counter never exceeds it.
  localparam logic [7:0] LP_CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic w_astb_s, w_dstb_s, w_write_s;

  logic [2:0]         r_state;
  logic               r_bus_oe;
  logic [DEPP_DW-1:0] r_rd_latch;
  logic [7:0]         r_cnt;
  logic               r_is_data;
  logic               r_is_read;

  depp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (
    .clk(clk), .rst_n(rst_n), .i_rst_val(1'b1), .i_d(a_astb),  .o_q(w_astb_s)
  );
  depp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (
    .clk(clk), .rst_n(rst_n), .i_rst_val(1'b1), .i_d(a_dstb),  .o_q(w_dstb_s)
  );
  depp_sync #(.STAGES(SYNC_STAGES)) u_sync_write (
    .clk(clk), .rst_n(rst_n), .i_rst_val(1'b0), .i_d(a_write), .o_q(w_write_s)
  );

  assign a_db = r_bus_oe ? r_rd_latch : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bus_oe   <= 1'b0;
      r_rd_latch <= '0;
      r_cnt      <= '0;
      r_is_data  <= 1'b0;
      r_is_read  <= 1'b0;
      a_wait     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      timeout    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Address strobe has priority when both strobes are low.
          if (!w_astb_s) begin
            proto_err <= !w_dstb_s;
            r_is_data <= 1'b0;
            r_state   <= ST_ADDR;
          end else if (!w_dstb_s) begin
            r_is_data <= 1'b1;
            r_is_read <= w_write_s;
            r_cnt     <= '0;
            if (w_write_s) begin
              reg_re <= 1'b1;
            end else begin
              reg_wdata <= a_db;
              reg_we    <= 1'b1;
            end
            r_state <= ST_DREQ;
          end
        end

        ST_ADDR: begin
          if (!w_write_s) begin
            reg_addr <= a_db;
          end else begin
            r_rd_latch <= reg_addr;
            r_bus_oe   <= 1'b1;
          end
          a_wait  <= 1'b1;
          r_state <= ST_HOLD;
        end

        ST_DREQ, ST_DWAIT: begin
          r_state <= ST_DWAIT;
          if (reg_ack) begin
            if (r_is_read) begin
              r_rd_latch <= reg_rdata;
              r_bus_oe   <= 1'b1;
            end
            a_wait  <= 1'b1;
            r_state <= ST_HOLD;
          end else if (r_cnt >= LP_CNT_LAST) begin
            timeout <= 1'b1;
            if (r_is_read) begin
              r_rd_latch <= TIMEOUT_RDATA;
              r_bus_oe   <= 1'b1;
            end
            a_wait  <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          if (r_is_data ? w_dstb_s : w_astb_s) begin
            a_wait   <= 1'b0;
            r_bus_oe <= 1'b0;
            r_state  <= ST_IDLE;
`ifdef DEPP_AUTOINC_EN
            if (r_is_data) reg_addr <= reg_addr + 8'd1;
`else
            reg_addr <= reg_addr;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_depp_reg_ctrl.sv
// Self-checking bench for depp_reg_ctrl: table vectors, hand-written corner sequences, random host traffic.
module tb_depp_reg_ctrl;
  localparam int TO = 8;
`ifdef DEPP_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_astb = 1'b1;
  logic       a_dstb = 1'b1;
  logic       a_write = 1'b0;
  wire  [7:0] a_db;
  logic [7:0] host_db = 8'h00;
  logic       host_oe = 1'b0;
  logic       a_wait;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       timeout, proto_err;

  assign a_db = host_oe ? host_db : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (a_db[gi]);
  end

  depp_reg_ctrl #(.SYNC_STAGES(2), .ACK_TIMEOUT(TO), .TIMEOUT_RDATA(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .a_astb(a_astb), .a_dstb(a_dstb), .a_write(a_write),
    .a_db(a_db), .a_wait(a_wait), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .timeout(timeout), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, txn = 0;
  int cyc = 0, start_cyc = 0;
  int we_cnt = 0, re_cnt = 0, to_cnt = 0, pe_cnt = 0;
  int req_cyc = 0, to_cyc = 0;
  logic [7:0] last_wdata = 8'h00, last_we_addr = 8'h00;
  int ack_delay = 0, pend = 0;
  logic [7:0] m_addr = 8'h00;

  always @(posedge clk) cyc++;

  // Register-bus responder and pulse monitor; ack_delay < 0 means never acknowledge.
  always @(negedge clk) begin
    reg_ack = 1'b0;
    if (reg_we) begin we_cnt++; last_wdata = reg_wdata; last_we_addr = reg_addr; req_cyc = cyc; end
    if (reg_re) begin re_cnt++; req_cyc = cyc; end
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (proto_err) pe_cnt++;
    if (reg_we || reg_re) begin
      if (ack_delay == 0) reg_ack = 1'b1;
      else if (ack_delay > 0) pend = ack_delay;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) reg_ack = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_wait(input logic lvl, input int t0, output int lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (a_wait !== lvl && n < 100);
    lat = (a_wait === lvl) ? (cyc - t0) : -1;
  endtask

  task automatic host_cycle(input bit is_addr, input bit rd, input logic [7:0] wv,
                            output logic [7:0] rv, output int rl, output int fl,
                            output logic [7:0] rel_db);
    int t_rel;
    @(negedge clk);
    a_write = rd; host_db = wv; host_oe = !rd;
    if (is_addr) a_astb = 1'b0; else a_dstb = 1'b0;
    start_cyc = cyc;
    wait_wait(1'b1, start_cyc, rl);
    rv = a_db;
    a_astb = 1'b1; a_dstb = 1'b1; host_oe = 1'b0;
    t_rel = cyc;
    wait_wait(1'b0, t_rel, fl);
    rel_db = a_db;
  endtask

  string opn[4] = '{"AW", "AR", "DW", "DR"};

  // op: 0 addr write, 1 addr read, 2 data write, 3 data read. exp: written/read address, or read data.
  task automatic do_op(input int op, input logic [7:0] data, input int dly, input logic [7:0] exp);
    int we0 = we_cnt, re0 = re_cnt, to0 = to_cnt;
    logic [7:0] rv, rel_db;
    int rl, fl, exp_rl;
    ack_delay = dly;
    reg_rdata = data;
    host_cycle(op < 2, (op == 1) || (op == 3), data, rv, rl, fl, rel_db);
    txn++;
    $display("txn %0d op=%s data=%h dly=%0d exp=%h rd=%h reg_addr=%h", txn, opn[op], data, dly, exp, rv, reg_addr);
    case (op)
      0: begin m_addr = data; check("addr_wr", reg_addr, exp); end
      1: check("addr_rd", rv, exp);
      2: begin
        check("we_cnt", we_cnt - we0, 1);
        check("wdata", last_wdata, data);
        check("we_addr", last_we_addr, exp);
        check("we_lat", req_cyc - start_cyc, 3);
      end
      default: begin
        check("re_cnt", re_cnt - re0, 1);
        check("rd_data", rv, exp);
        if (exp != 8'hFF) check("rd_release", rel_db, 8'hFF);
      end
    endcase
    if (op >= 2) begin
      check("to_cnt", to_cnt - to0, (dly < 0) ? 1 : 0);
      if (dly < 0) check("to_lat", to_cyc - req_cyc, TO);
      if (AI) m_addr = m_addr + 8'd1;
      check("addr_after", reg_addr, m_addr);
    end else begin
      check("no_access", (we_cnt - we0) + (re_cnt - re0), 0);
    end
    exp_rl = (op < 2) ? 4 : ((dly < 0) ? 3 + TO : 4 + dly);
    check("wait_rise", rl, exp_rl);
    check("wait_fall", fl, 3);
  endtask

  typedef struct {
    int         op;
    logic [7:0] data;
    int         dly;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rl, fl, pe0, acc0, op, dly;
    logic [7:0] d, e;

    vecs[0]  = '{0, 8'h3C, 0, 8'h3C};
    vecs[1]  = '{1, 8'h00, 0, 8'h3C};
    vecs[2]  = '{0, 8'h10, 0, 8'h10};
    vecs[3]  = '{2, 8'hA5, 1, 8'h10};
    vecs[4]  = '{0, 8'h20, 0, 8'h20};
    vecs[5]  = '{3, 8'h5A, 4, 8'h5A};
    vecs[6]  = '{0, 8'h20, 0, 8'h20};
    vecs[7]  = '{3, 8'h42, -1, 8'hFF};
    vecs[8]  = '{0, 8'hFE, 0, 8'hFE};
    vecs[9]  = '{2, 8'h11, 0, 8'hFE};
    vecs[10] = '{2, 8'h22, 2, AI ? 8'hFF : 8'hFE};
    vecs[11] = '{2, 8'h33, 0, AI ? 8'h00 : 8'hFE};
    vecs[12] = '{1, 8'h00, 0, AI ? 8'h01 : 8'hFE};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_wait", a_wait, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_timeout", timeout, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_a_db", a_db, 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) do_op(vecs[i].op, vecs[i].data, vecs[i].dly, vecs[i].exp);

    // Both strobes low together: address write wins and proto_err pulses once.
    pe0 = pe_cnt; acc0 = we_cnt + re_cnt;
    @(negedge clk);
    a_write = 1'b0; host_db = 8'h77; host_oe = 1'b1; a_astb = 1'b0; a_dstb = 1'b0;
    start_cyc = cyc;
    wait_wait(1'b1, start_cyc, rl);
    a_astb = 1'b1; a_dstb = 1'b1; host_oe = 1'b0;
    start_cyc = cyc;
    wait_wait(1'b0, start_cyc, fl);
    txn++;
    $display("txn %0d op=BOTH data=77 reg_addr=%h", txn, reg_addr);
    m_addr = 8'h77;
    check("pe_cnt", pe_cnt - pe0, 1);
    check("pe_addr", reg_addr, 8'h77);
    check("pe_no_access", (we_cnt + re_cnt) - acc0, 0);
    check("pe_wait_rise", rl, 4);
    check("pe_wait_fall", fl, 3);

    // Reset asserted while a read is holding the bus.
    ack_delay = 0; reg_rdata = 8'h3C;
    @(negedge clk);
    a_write = 1'b1; a_dstb = 1'b0;
    start_cyc = cyc;
    wait_wait(1'b1, start_cyc, rl);
    txn++;
    $display("txn %0d op=DR_RST data=3C rd=%h", txn, a_db);
    check("hold_rd_data", a_db, 8'h3C);
    rst_n = 1'b0;
    #1;
    check("rst_hold_wait", a_wait, 0);
    check("rst_hold_db", a_db, 8'hFF);
    a_dstb = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_addr = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_hold_addr", reg_addr, 8'h00);
    check("rst_hold_idle_wait", a_wait, 0);

    // Random host traffic against the address/data model.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      d = 8'($urandom_range(0, 255));
      dly = 0;
      if (op >= 2) dly = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 6);
      case (op)
        0:       e = d;
        1:       e = m_addr;
        2:       e = m_addr;
        default: e = (dly < 0) ? 8'hFF : d;
      endcase
      do_op(op, d, dly, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
